fetch_warp_scheduler: RTL and testbench

//  Chooses which warps fetch each cycle into the two fetch/decode lanes (lane0->ID0, lane1->ID1).

---
 rtl/gpu_sched_pkg.sv | 10 +
 rtl/rr_pick.sv | 36 +++
 rtl/fetch_warp_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_fetch_warp_scheduler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/gpu_sched_pkg.sv
// Shared constants for the warp fetch scheduler: default sizing, credit width
// and fetch-lane indices.
`timescale 1ns/1ps
package gpu_sched_pkg;
    localparam int DEF_NUM_WARPS = 8;
    localparam int DEF_IB_DEPTH  = 4;
    localparam int CREDIT_W      = $clog2(DEF_IB_DEPTH + 1);
    localparam int LANE0         = 0;
    localparam int LANE1         = 1;
endpackage

// File: rtl/rr_pick.sv
// Combinational masked round-robin picker: first set bit of req scanning
// ptr, ptr+1, ... modulo N.
`timescale 1ns/1ps
module rr_pick #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);
    logic [IW:0]   sum;
    logic [IW-1:0] sel;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        sel   = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            sel = sum[IW-1:0];
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                idx        = sel;
            end
        end
    end
endmodule

// File: rtl/fetch_warp_scheduler.sv
// Two-lane round-robin warp fetch scheduler with per-warp I-buffer credits.
// Optional SCHED_PERF_CNT_EN adds grant/idle performance counters.
`timescale 1ns/1ps
module fetch_warp_scheduler
    import gpu_sched_pkg::*;
#(
    parameter int NUM_WARPS = DEF_NUM_WARPS,
    parameter int IB_DEPTH  = DEF_IB_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_WARPS-1:0] Start_Host_Sched,
    input  logic [NUM_WARPS-1:0] Valid_3_ID0_Sched,
    input  logic [NUM_WARPS-1:0] Valid_3_ID1_Sched,
    input  logic                 Exit_ID0_Sched,
    input  logic                 Exit_ID1_Sched,
    input  logic                 Branch_ID0_Sched,
    input  logic                 Branch_ID1_Sched,
    input  logic [NUM_WARPS-1:0] BrResolved_SIMT_Sched,
    input  logic [NUM_WARPS-1:0] CreditRet_IB_Sched,
    input  logic [NUM_WARPS-1:0] Flush_IB_Sched,
    output logic [NUM_WARPS-1:0] Valid_1_Sched_IF0,
    output logic [NUM_WARPS-1:0] Valid_1_Sched_IF1,
    output logic [NUM_WARPS-1:0] Active_Sched,
    output logic                 AllExited_Sched
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]          Perf_Grant_Cnt,
    output logic [31:0]          Perf_Idle_Cnt
`endif
);
    localparam int WIW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int CW  = $clog2(IB_DEPTH + 1);
    localparam logic [CW-1:0]  CREDIT_MAX = CW'(IB_DEPTH);
    localparam logic [CW-1:0]  CREDIT_ONE = CW'(1);
    localparam logic [WIW-1:0] LAST_WARP  = WIW'(NUM_WARPS - 1);

    logic [NUM_WARPS-1:0] active_q, active_d;
    logic [NUM_WARPS-1:0] inflight_q, inflight_d;
    logic [NUM_WARPS-1:0] brstall_q, brstall_d;
    logic [CW-1:0]        credit_q [NUM_WARPS];
    logic [CW-1:0]        credit_d [NUM_WARPS];
    logic [WIW-1:0]       ptr_q, ptr_d;
    logic                 started_q, started_d;
    logic                 all_exited_q, all_exited_d;
    logic [NUM_WARPS-1:0] grant0_q, grant1_q;

    logic [NUM_WARPS-1:0] eligible;
    logic [NUM_WARPS-1:0] gnt [2];
    logic [WIW-1:0]       idx [2];
    logic                 found [2];
    logic [WIW-1:0]       ptr1;
    logic [NUM_WARPS-1:0] granted, decoded, do_exit, do_branch, start_new;

    always_comb begin
        eligible = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            eligible[w] = active_q[w] & ~inflight_q[w] & ~brstall_q[w] & (credit_q[w] != '0);
        end
    end

    // Lane1 continues the scan just past lane0's winner, excluding it.
    assign ptr1 = (idx[LANE0] == LAST_WARP) ? '0 : idx[LANE0] + 1'b1;

    rr_pick #(.N(NUM_WARPS), .IW(WIW)) u_pick0 (
        .req   (eligible),
        .ptr   (ptr_q),
        .grant (gnt[LANE0]),
        .idx   (idx[LANE0]),
        .found (found[LANE0])
    );

    rr_pick #(.N(NUM_WARPS), .IW(WIW)) u_pick1 (
        .req   (eligible & ~gnt[LANE0]),
        .ptr   (ptr1),
        .grant (gnt[LANE1]),
        .idx   (idx[LANE1]),
        .found (found[LANE1])
    );

    assign granted   = gnt[LANE0] | gnt[LANE1];
    assign decoded   = Valid_3_ID0_Sched | Valid_3_ID1_Sched;
    assign do_exit   = (Valid_3_ID0_Sched & {NUM_WARPS{Exit_ID0_Sched}})
                     | (Valid_3_ID1_Sched & {NUM_WARPS{Exit_ID1_Sched}});
    assign do_branch = (Valid_3_ID0_Sched & {NUM_WARPS{Branch_ID0_Sched}})
                     | (Valid_3_ID1_Sched & {NUM_WARPS{Branch_ID1_Sched}});
    assign start_new = Start_Host_Sched & ~active_q;

    // Later assignments take priority: flush over grant, start over credits, exit over all.
    always_comb begin
        active_d   = active_q;
        inflight_d = inflight_q;
        brstall_d  = brstall_q;
        credit_d   = credit_q;
        started_d  = started_q;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (decoded[w])               inflight_d[w] = 1'b0;
            if (granted[w])               inflight_d[w] = 1'b1;
            if (BrResolved_SIMT_Sched[w]) brstall_d[w]  = 1'b0;
            if (do_branch[w])             brstall_d[w]  = 1'b1;
            if (Flush_IB_Sched[w]) begin
                credit_d[w]   = CREDIT_MAX;
                inflight_d[w] = 1'b0;
            end else if (granted[w] && !CreditRet_IB_Sched[w]) begin
                credit_d[w] = credit_q[w] - CREDIT_ONE;
            end else if (!granted[w] && CreditRet_IB_Sched[w] && credit_q[w] != CREDIT_MAX) begin
                credit_d[w] = credit_q[w] + CREDIT_ONE;
            end
            if (start_new[w]) begin
                active_d[w]   = 1'b1;
                credit_d[w]   = CREDIT_MAX;
                brstall_d[w]  = 1'b0;
                inflight_d[w] = 1'b0;
                started_d     = 1'b1;
            end
            if (do_exit[w]) begin
                active_d[w]  = 1'b0;
                brstall_d[w] = 1'b0;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found[LANE1]) begin
            ptr_d = (idx[LANE1] == LAST_WARP) ? '0 : idx[LANE1] + 1'b1;
        end else if (found[LANE0]) begin
            ptr_d = ptr1;
        end
        all_exited_d = started_d & ~|active_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q     <= '0;
            inflight_q   <= '0;
            brstall_q    <= '0;
            ptr_q        <= '0;
            started_q    <= 1'b0;
            all_exited_q <= 1'b0;
            grant0_q     <= '0;
            grant1_q     <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                credit_q[w] <= CREDIT_MAX;
            end
        end else begin
            active_q     <= active_d;
            inflight_q   <= inflight_d;
            brstall_q    <= brstall_d;
            ptr_q        <= ptr_d;
            started_q    <= started_d;
            all_exited_q <= all_exited_d;
            grant0_q     <= gnt[LANE0];
            grant1_q     <= gnt[LANE1];
            credit_q     <= credit_d;
        end
    end

    assign Valid_1_Sched_IF0 = grant0_q;
    assign Valid_1_Sched_IF1 = grant1_q;
    assign Active_Sched      = active_q;
    assign AllExited_Sched   = all_exited_q;

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_grant_q, perf_grant_d;
    logic [31:0] perf_idle_q, perf_idle_d;

    always_comb begin
        perf_grant_d = perf_grant_q + 32'(found[LANE0]) + 32'(found[LANE1]);
        perf_idle_d  = perf_idle_q + ((|active_q && !found[LANE0]) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grant_q <= '0;
            perf_idle_q  <= '0;
        end else begin
            perf_grant_q <= perf_grant_d;
            perf_idle_q  <= perf_idle_d;
        end
    end

    assign Perf_Grant_Cnt = perf_grant_q;
    assign Perf_Idle_Cnt  = perf_idle_q;
`endif
endmodule

// File: tb/tb_fetch_warp_scheduler.sv
// Directed bench for fetch_warp_scheduler: round-robin pairs, credits,
// branch stall, exit, flush priority, start/exit collision, async reset.
`timescale 1ns/1ps
module tb_fetch_warp_scheduler;
    logic       clk;
    logic       rst_n;
    logic [7:0] start, v3_0, v3_1, br_res, cred_ret, flush;
    logic       ex0, ex1, br0, br1;
    logic [7:0] if0, if1, active;
    logic       all_exited;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_grant, perf_idle;
`endif

    int total = 0;
    int bad   = 0;

    fetch_warp_scheduler dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .Start_Host_Sched      (start),
        .Valid_3_ID0_Sched     (v3_0),
        .Valid_3_ID1_Sched     (v3_1),
        .Exit_ID0_Sched        (ex0),
        .Exit_ID1_Sched        (ex1),
        .Branch_ID0_Sched      (br0),
        .Branch_ID1_Sched      (br1),
        .BrResolved_SIMT_Sched (br_res),
        .CreditRet_IB_Sched    (cred_ret),
        .Flush_IB_Sched        (flush),
        .Valid_1_Sched_IF0     (if0),
        .Valid_1_Sched_IF1     (if1),
        .Active_Sched          (active),
        .AllExited_Sched       (all_exited)
`ifdef SCHED_PERF_CNT_EN
        ,
        .Perf_Grant_Cnt        (perf_grant),
        .Perf_Idle_Cnt         (perf_idle)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        start = '0; v3_0 = '0; v3_1 = '0; br_res = '0; cred_ret = '0; flush = '0;
        ex0 = 1'b0; ex1 = 1'b0; br0 = 1'b0; br1 = 1'b0;
    endtask

    // Inputs set before tick are sampled at its edge; outputs read after it.
    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic do_reset(input string tag);
        clear_inputs();
        rst_n = 1'b0;
        #2;
        check({tag, "_rst_if0"}, 32'(if0), 32'h0);
        check({tag, "_rst_act"}, 32'(active), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_grant(input string tag, input logic [7:0] e0, input logic [7:0] e1);
        check({tag, "_if0"}, 32'(if0), 32'(e0));
        check({tag, "_if1"}, 32'(if1), 32'(e1));
    endtask

    // Grant, idle cycle, then decode echo two cycles after the grant.
    task automatic run_grants(input string tag, input logic [7:0] m, input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            check_grant({tag, "_g"}, m, 8'h00);
            tick();
            check_grant({tag, "_w"}, 8'h00, 8'h00);
            v3_0 = m;
            tick();
            check_grant({tag, "_d"}, 8'h00, 8'h00);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        clear_inputs();
        #3;

        // 1: all warps, pairs in order, then bubbles until decode
        do_reset("t1");
        check_grant("t1_idle", 8'h00, 8'h00);
        check("t1_allex0", 32'(all_exited), 32'h0);
        start = 8'hFF;
        tick();
        check("t1_act", 32'(active), 32'hFF);
        check_grant("t1_first", 8'h00, 8'h00);
        tick(); check_grant("t1_p01", 8'h01, 8'h02);
        tick(); check_grant("t1_p23", 8'h04, 8'h08);
        tick(); check_grant("t1_p45", 8'h10, 8'h20);
        tick(); check_grant("t1_p67", 8'h40, 8'h80);
        tick(); check_grant("t1_bub", 8'h00, 8'h00);
        v3_0 = 8'h01; v3_1 = 8'h02;
        tick(); check_grant("t1_dec", 8'h00, 8'h00);
        tick(); check_grant("t1_wrap", 8'h01, 8'h02);

        // 2: single warp exhausts four credits, one return re-enables it
        do_reset("t2");
        start = 8'h08;
        tick();
        run_grants("t2", 8'h08, 4);
        for (int k = 0; k < 3; k++) begin
            tick(); check_grant("t2_nocred", 8'h00, 8'h00);
        end
        cred_ret = 8'h08;
        tick(); check_grant("t2_ret", 8'h00, 8'h00);
        tick(); check_grant("t2_regrant", 8'h08, 8'h00);

        // 3: branch stall until SIMT resolution
        do_reset("t3");
        start = 8'h04;
        tick();
        tick(); check_grant("t3_g", 8'h04, 8'h00);
        tick();
        v3_0 = 8'h04; br0 = 1'b1;
        tick(); check_grant("t3_dec", 8'h00, 8'h00);
        tick(); check_grant("t3_stall1", 8'h00, 8'h00);
        tick(); check_grant("t3_stall2", 8'h00, 8'h00);
        br_res = 8'h04;
        tick(); check_grant("t3_res", 8'h00, 8'h00);
        tick(); check_grant("t3_after", 8'h04, 8'h00);

        // 4: exits on both lanes
        do_reset("t4");
        start = 8'h03;
        tick();
        check("t4_act", 32'(active), 32'h03);
        check("t4_allex0", 32'(all_exited), 32'h0);
        tick(); check_grant("t4_g", 8'h01, 8'h02);
        v3_1 = 8'h02; ex1 = 1'b1;
        tick();
        check("t4_act1", 32'(active), 32'h01);
        check("t4_allex1", 32'(all_exited), 32'h0);
        v3_0 = 8'h01; ex0 = 1'b1;
        tick();
        check("t4_act2", 32'(active), 32'h00);
        check("t4_allex2", 32'(all_exited), 32'h1);
        check_grant("t4_none", 8'h00, 8'h00);

        // 5: flush beats credit return; restores a full four credits
        do_reset("t5");
        start = 8'h20;
        tick();
        run_grants("t5a", 8'h20, 4);
        tick(); check_grant("t5_empty", 8'h00, 8'h00);
        flush = 8'h20; cred_ret = 8'h20;
        tick(); check_grant("t5_flush", 8'h00, 8'h00);
        run_grants("t5b", 8'h20, 4);
        tick(); check_grant("t5_empty2", 8'h00, 8'h00);

        // 6: start and exit collide; async reset mid-run
        do_reset("t6");
        start = 8'h10; v3_0 = 8'h10; ex0 = 1'b1;
        tick();
        check("t6_act", 32'(active), 32'h00);
        tick(); check_grant("t6_nogrant", 8'h00, 8'h00);
        start = 8'hFF;
        tick();
        tick(); check_grant("t6_run", 8'h01, 8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        check_grant("t6_async", 8'h00, 8'h00);
        check("t6_async_act", 32'(active), 32'h00);
        check("t6_async_allex", 32'(all_exited), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(); check_grant("t6_post", 8'h00, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
